// File: rtl/cpu_responder.sv
// rtl/cpu_responder.sv - direct-mapped line cache responder for the core request port
//
// Accepts one core request at a time, answers with a one-cycle cpu_resp after
// HIT_LAT or MISS_LAT cycles. A small direct-mapped cache sits in front of a
// zero-initialised backing line store (write-through, write-allocate).
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   cpu_req      request valid, held by the core until cpu_resp
//   cpu_we       1 = write, 0 = read
//   cpu_addr     byte address (offset bits ignored)
//   cpu_wdata    full-line write data
//   cpu_ready    idle, a request will be accepted
//   cpu_resp     one-cycle completion pulse
//   cpu_rdata    read line, non-zero only in a read response cycle
//   hit_cnt      saturating count of completed hits
//   miss_cnt     saturating count of completed misses

package types;
  parameter int XLEN = 32;
  parameter int CACHELINE_SIZE = 64;
endpackage

module cpu_responder
  import types::*;
#(
  parameter int SETS      = 4,
  parameter int MEM_LINES = 64,
  parameter int HIT_LAT   = 1,
  parameter int MISS_LAT  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [XLEN-1:0]           cpu_addr,
  input  logic [CACHELINE_SIZE-1:0] cpu_wdata,
  output logic                      cpu_ready,
  output logic                      cpu_resp,
  output logic [CACHELINE_SIZE-1:0] cpu_rdata,
  output logic [15:0]               hit_cnt,
  output logic [15:0]               miss_cnt
);

  localparam int OFF    = $clog2(CACHELINE_SIZE / 8);
  localparam int SET_W  = $clog2(SETS);
  localparam int MEM_W  = $clog2(MEM_LINES);
  localparam int LINE_W = XLEN - OFF;
  localparam int TAG_W  = LINE_W - SET_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;
  state_t state, state_next;

  // Latched request
  logic                      req_we;
  logic [LINE_W-1:0]         req_line;
  logic [CACHELINE_SIZE-1:0] req_wdata;
  logic                      req_hit;
  // Remaining BUSY cycles; RESP follows the cycle in which it reads 1
  logic [5:0]                lat_cnt;

  // Cache and backing store
  logic [SETS-1:0]           valid;
  logic [TAG_W-1:0]          tags  [SETS];
  logic [CACHELINE_SIZE-1:0] lines [SETS];
  logic [CACHELINE_SIZE-1:0] mem   [MEM_LINES];
  logic [CACHELINE_SIZE-1:0] rdata_q;

  // Lookup of the live request, used only at accept time
  logic [LINE_W-1:0] in_line;
  logic [SET_W-1:0]  in_set;
  logic [TAG_W-1:0]  in_tag;
  logic              in_hit;
  logic [5:0]        in_lat;
  logic              unused_offset;

  assign in_line       = cpu_addr[XLEN-1:OFF];
  assign unused_offset = ^cpu_addr[OFF-1:0];
  assign in_set        = in_line[SET_W-1:0];
  assign in_tag        = in_line[LINE_W-1:SET_W];
  assign in_hit        = valid[in_set] && (tags[in_set] == in_tag);
  assign in_lat        = in_hit ? 6'(HIT_LAT) : 6'(MISS_LAT);

  // Commit source: a one-cycle hit commits straight from the live inputs,
  // everything else from the latched request.
  logic                      commit;
  logic                      c_we;
  logic                      c_hit;
  logic [LINE_W-1:0]         c_line;
  logic [CACHELINE_SIZE-1:0] c_wdata;
  logic [SET_W-1:0]          c_set;
  logic [TAG_W-1:0]          c_tag;
  logic [MEM_W-1:0]          c_mem;

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    c_we       = req_we;
    c_hit      = req_hit;
    c_line     = req_line;
    c_wdata    = req_wdata;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          c_we    = cpu_we;
          c_hit   = in_hit;
          c_line  = in_line;
          c_wdata = cpu_wdata;
          if (in_lat == 6'd1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (lat_cnt == 6'd1) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign c_set = c_line[SET_W-1:0];
  assign c_tag = c_line[LINE_W-1:SET_W];
  assign c_mem = c_line[MEM_W-1:0];

  assign cpu_ready = (state == IDLE);
  assign cpu_resp  = (state == RESP);
  assign cpu_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      rdata_q   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      lat_cnt   <= '0;
      req_we    <= 1'b0;
      req_line  <= '0;
      req_wdata <= '0;
      req_hit   <= 1'b0;
      for (int i = 0; i < SETS; i++) begin
        tags[i]  <= '0;
        lines[i] <= '0;
      end
      for (int i = 0; i < MEM_LINES; i++) mem[i] <= '0;
    end else begin
      rdata_q <= '0;
      if (state == IDLE && cpu_req) begin
        req_we    <= cpu_we;
        req_line  <= in_line;
        req_wdata <= cpu_wdata;
        req_hit   <= in_hit;
        lat_cnt   <= in_lat - 6'd1;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - 6'd1;
      end

      if (commit) begin
        if (c_we) begin
          mem[c_mem]   <= c_wdata;
          lines[c_set] <= c_wdata;
          tags[c_set]  <= c_tag;
          valid[c_set] <= 1'b1;
        end else if (c_hit) begin
          rdata_q <= lines[c_set];
        end else begin
          rdata_q      <= mem[c_mem];
          lines[c_set] <= mem[c_mem];
          tags[c_set]  <= c_tag;
          valid[c_set] <= 1'b1;
        end
        if (c_hit) begin
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end
    end
  end

endmodule
